// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: loads a reference history, trains one window,
// then counts bit errors against a self-running reference while locked.
module ber_checker #(
    parameter int unsigned NB_ERR  = 32,
    parameter int unsigned WIN_LEN = 128,
    parameter int unsigned ERR_THR = 4
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_data,
    output logic              o_locked,
    output logic              o_sync_loss,
    output logic [NB_ERR-1:0] o_err_count,
    output logic [NB_ERR-1:0] o_bit_count
);

    localparam int unsigned HIST_W = 9;
    localparam int unsigned LOAD_W = 4;
    localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);

    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(HIST_W - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [NB_ERR-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_TRAIN,
        ST_LOCKED
    } state_t;

    state_t            state;
    logic [HIST_W-1:0] hist;
    logic [LOAD_W-1:0] load_cnt;
    logic [WIN_W-1:0]  win_pos;
    logic [WIN_W-1:0]  win_err;

    logic              expected_c;
    logic              bit_err_c;
    logic              win_end_c;
    logic              win_pass_c;
    logic [HIST_W-1:0] hist_rx_c;
    logic [WIN_W-1:0]  win_err_nxt_c;

    // Reference prediction and window bookkeeping for the bit on i_data.
    always_comb begin
        expected_c    = hist[8] ^ hist[4];
        bit_err_c     = i_data ^ expected_c;
        hist_rx_c     = {hist[HIST_W-2:0], i_data};
        win_end_c     = (win_pos == WIN_LAST);
        win_err_nxt_c = win_err + WIN_W'(bit_err_c);
        win_pass_c    = (32'(win_err_nxt_c) <= ERR_THR);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= ST_LOAD;
            hist        <= '0;
            load_cnt    <= '0;
            win_pos     <= '0;
            win_err     <= '0;
            o_locked    <= 1'b0;
            o_sync_loss <= 1'b0;
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (i_enable) begin
            o_sync_loss <= 1'b0;
            if (i_valid) begin
                case (state)
                    ST_LOAD: begin
                        hist <= hist_rx_c;
                        if (load_cnt == LOAD_LAST) begin
                            state    <= ST_TRAIN;
                            load_cnt <= '0;
                            win_pos  <= '0;
                            win_err  <= '0;
                        end else begin
                            load_cnt <= load_cnt + LOAD_W'(1);
                        end
                    end

                    ST_TRAIN: begin
                        hist <= hist_rx_c;
                        if (win_end_c) begin
                            win_pos <= '0;
                            win_err <= '0;
                            // A zero history would make the reference stick at zero forever.
                            if (win_pass_c && (hist_rx_c != '0)) begin
                                state       <= ST_LOCKED;
                                o_locked    <= 1'b1;
                                o_err_count <= '0;
                                o_bit_count <= '0;
                            end else begin
                                state    <= ST_LOAD;
                                load_cnt <= '0;
                            end
                        end else begin
                            win_pos <= win_pos + WIN_W'(1);
                            win_err <= win_err_nxt_c;
                        end
                    end

                    ST_LOCKED: begin
                        // Free-running reference so received errors never corrupt it.
                        hist <= {hist[HIST_W-2:0], expected_c};
                        if (o_bit_count != CNT_MAX) begin
                            o_bit_count <= o_bit_count + NB_ERR'(1);
                        end
                        if (bit_err_c && (o_err_count != CNT_MAX)) begin
                            o_err_count <= o_err_count + NB_ERR'(1);
                        end
                        if (win_end_c) begin
                            win_pos <= '0;
                            win_err <= '0;
                            if (!win_pass_c) begin
                                state       <= ST_LOAD;
                                load_cnt    <= '0;
                                o_locked    <= 1'b0;
                                o_sync_loss <= 1'b1;
                            end
                        end else begin
                            win_pos <= win_pos + WIN_W'(1);
                            win_err <= win_err_nxt_c;
                        end
                    end

                    default: begin
                        state    <= ST_LOAD;
                        load_cnt <= '0;
                        win_pos  <= '0;
                        win_err  <= '0;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_ERR, default 32: width of the error and bit counters.
REQ-002 Parameter WIN_LEN, default 128: number of symbols per lock-evaluation window.
REQ-003 Parameter ERR_THR, default 4: maximum errors per window that still counts as in-sync.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_enable  in  1  high = block runs; low = all state, counters and outputs hold, and i_valid is ignored.
REQ-007 i_valid  in  1  symbol strobe; one received bit per high cycle, any spacing (nominally 1 in 8 clocks).
REQ-008 i_data  in  1  received hard-decision bit, sampled only when i_valid && i_enable.
REQ-009 o_locked  out  1  registered; high while in state LOCKED.
REQ-010 o_sync_loss  out  1  one-cycle pulse on LOCKED -> LOAD transition.
REQ-011 o_err_count  out  NB_ERR  accumulated bit errors since last lock entry, saturating.
REQ-012 o_bit_count  out  NB_ERR  accumulated checked bits since last lock entry, saturating.

Function
REQ-013 The block SHALL check a PRBS9 stream obeying b[n] = b[n-9] XOR b[n-5].
REQ-014 It SHALL keep a 9-bit history hist, hist[0] newest; expected = hist[8] XOR hist[4]; error = i_data != expected.
REQ-015 FSM states SHALL be LOAD, TRAIN, LOCKED; reset state is LOAD.
REQ-016 LOAD: each accepted bit shifts i_data into hist; after the 9th accepted bit, next state is TRAIN.
REQ-017 TRAIN: each accepted bit is compared; hist shifts in i_data; the window error count increments on error.
REQ-018 At the end of TRAIN (the WIN_LEN-th accepted bit), the block SHALL enter LOCKED if window errors <= ERR_THR and hist is not all-zero; otherwise it SHALL return to LOAD with the load counter cleared.
REQ-019 LOCKED: hist SHALL shift in expected, not i_data, so that received errors do not propagate into the reference.
REQ-020 LOCKED: each accepted bit increments o_bit_count; each error increments o_err_count; both saturate at all-ones and hold there.
REQ-021 LOCKED: windows of WIN_LEN bits repeat; a window ending with errors > ERR_THR SHALL send the FSM to LOAD and pulse o_sync_loss.
REQ-022 Window error and window position counters SHALL clear at every window end and on every state change.
REQ-023 On the TRAIN -> LOCKED transition, o_err_count and o_bit_count SHALL clear to 0; after loss of lock they hold their last values until the next lock.
REQ-024 Counter and flag outputs SHALL update on the clock edge following the accepted bit (latency 1).
REQ-025 A bit accepted on the same cycle as a window end SHALL be counted in that window.
REQ-026 The error on the transition bit SHALL be counted before the transition is taken.
REQ-027 An all-zero or constant stream SHALL never reach LOCKED.

Reset
REQ-028 i_reset high SHALL, at the next edge, force LOAD, hist = 0, and all internal counters = 0.
REQ-029 Reset SHALL also force o_locked = 0, o_sync_loss = 0, o_err_count = 0 and o_bit_count = 0.
REQ-030 Reset SHALL take priority over i_enable and i_valid, including mid-window or while locked.

Verification
REQ-031 Error-free PRBS9 stream, valid every 8 clocks, defaults -> o_locked rises 1 clock after the 137th valid; o_err_count stays 0; o_bit_count tracks valids after lock.
REQ-032 After lock, flip 1 bit every 64 bits for 1024 bits -> o_err_count = 16, o_bit_count = 1024, o_locked stays 1, no o_sync_loss.
REQ-033 After lock, switch to an inverted stream -> o_sync_loss pulses exactly once at the end of the current window, o_locked = 0, and the block never relocks; o_err_count holds.
REQ-034 All-zero i_data for 1000 valids -> o_locked stays 0 throughout.
REQ-035 i_enable low for 50 clocks mid-TRAIN with i_valid toggling -> no state or counter change; lock time is extended only by the ignored valids.
REQ-036 i_reset pulsed while locked with o_err_count = 3 -> all outputs are 0 next cycle, and lock is reacquired after 137 further valids.
